coder_pos_trigger: RTL and testbench

//  Parametrised quadrature-coder front end for the EMAT thickness system. It replaces the

---
 rtl/coder_pos_trigger_if.sv | 30 +++
 rtl/coder_pos_trigger.sv | 222 ++++++++++++++++++++++
 tb/tb_coder_pos_trigger.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coder_pos_trigger_if.sv
// Coder front-end bus: raw coder pins and control in, position and trigger status out.
interface coder_pos_trigger_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned TCNT_W = 16
);
  logic              coder_a;
  logic              coder_b;
  logic              en;
  logic              clr;
  logic [1:0]        dir_mode;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  pos;
  logic              dir;
  logic              quad_err;
  logic              trig_pulse;
  logic [TCNT_W-1:0] trig_cnt;

  // Register-file / pin side that drives the block
  modport master (
    output coder_a, coder_b, en, clr, dir_mode, step,
    input  pos, dir, quad_err, trig_pulse, trig_cnt
  );

  // The coder front end itself
  modport slave (
    input  coder_a, coder_b, en, clr, dir_mode, step,
    output pos, dir, quad_err, trig_pulse, trig_cnt
  );
endinterface

// File: rtl/coder_pos_trigger.sv
// Quadrature coder front end: sync, glitch filter, decode to signed position,
// illegal-transition flag and distance-based trigger pulse generation.
module coder_pos_trigger #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned FILT_LEN  = 4,
  parameter int unsigned PULSE_LEN = 8,
  parameter int unsigned TCNT_W    = 16
) (
  input  logic               clk_sys,
  input  logic               RESET_N,
  coder_pos_trigger_if.slave bus
);

  localparam int unsigned DIST_W = STEP_W + 1;
  localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned WCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [FCNT_W-1:0] FILT_LAST  = FCNT_W'(FILT_LEN - 1);
  localparam logic [WCNT_W-1:0] PULSE_LAST = WCNT_W'(PULSE_LEN - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pstate_e;

  // Next state in the forward sequence 00->01->11->10->00, as {A,B}
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  logic [1:0]             sync1_q, sync2_q;
  logic [1:0]             filt_q, filt_d;
  logic [1:0][FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]             prev_q, prev_d;
  logic                   vld_q, vld_d;
  logic [CNT_W-1:0]       pos_q, pos_d;
  logic                   dir_q, dir_d;
  logic                   qerr_q, qerr_d;
  logic [DIST_W-1:0]      dist_q, dist_d;
  logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
  pstate_e                state_q;
  logic [WCNT_W-1:0]      wcnt_q;
  logic                   pulse_q;

  logic              change_c, fwd_c, rev_c, err_c;
  logic              trig_en_c, dir_ok_c, fire_c;
  logic [DIST_W-1:0] dist_inc_c, step_ext_c;

  // Two-flop synchroniser for both raw phases
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {bus.coder_a, bus.coder_b};
      sync2_q <= sync1_q;
    end
  end

  // Per-phase stability filter: accept a level after FILT_LEN identical samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FILT_LAST) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
      end
    end
  end

  // Decode filtered {A,B} against the previous state
  always_comb begin
    change_c = vld_q && (filt_q != prev_q);
    fwd_c    = change_c && (filt_q == fwd_next(prev_q));
    rev_c    = change_c && (prev_q == fwd_next(filt_q));
    err_c    = change_c && !fwd_c && !rev_c;
  end

  // Travel distance with backlash rejection and trigger fire decision
  always_comb begin
    fire_c     = 1'b0;
    dist_d     = dist_q;
    trig_en_c  = bus.en && (bus.dir_mode != 2'b11);
    dir_ok_c   = (bus.dir_mode == 2'b00) ||
                 ((bus.dir_mode == 2'b01) && fwd_c) ||
                 ((bus.dir_mode == 2'b10) && rev_c);
    dist_inc_c = (dist_q == '1) ? dist_q : dist_q + DIST_W'(1);
    step_ext_c = DIST_W'(bus.step);
    if (!trig_en_c) begin
      dist_d = '0;
    end else if (fwd_c || rev_c) begin
      if (dir_ok_c) begin
        // >= so that a pitch lowered below the current distance fires on the next count
        if ((bus.step != '0) && (dist_inc_c >= step_ext_c)) begin
          fire_c = 1'b1;
          dist_d = '0;
        end else begin
          dist_d = dist_inc_c;
        end
      end else if (dist_q != '0) begin
        dist_d = dist_q - DIST_W'(1);
      end
    end
    if (bus.clr) begin
      fire_c = 1'b0;
      dist_d = '0;
    end
  end

  // Position, direction, error flag and trigger counter next state
  always_comb begin
    prev_d = prev_q;
    vld_d  = vld_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    qerr_d = qerr_q;
    tcnt_d = tcnt_q;
    if (!vld_q) begin
      prev_d = filt_q;
      vld_d  = 1'b1;
    end else if (change_c) begin
      prev_d = filt_q;
    end
    if (fwd_c) begin
      pos_d = pos_q + CNT_W'(1);
      dir_d = 1'b1;
    end else if (rev_c) begin
      pos_d = pos_q - CNT_W'(1);
      dir_d = 1'b0;
    end
    if (err_c) begin
      qerr_d = 1'b1;
    end
    if (fire_c) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
    end
    if (bus.clr) begin
      pos_d  = '0;
      dir_d  = dir_q;
      tcnt_d = '0;
      qerr_d = 1'b0;
      vld_d  = 1'b0;
    end
  end

  // Filter, decode and counter state registers
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      filt_q <= 2'b00;
      fcnt_q <= '0;
      prev_q <= 2'b00;
      vld_q  <= 1'b0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      qerr_q <= 1'b0;
      dist_q <= '0;
      tcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      qerr_q <= qerr_d;
      dist_q <= dist_d;
      tcnt_q <= tcnt_d;
    end
  end

  // Pulse FSM: fixed-width trigger, re-fire while high extends the pulse
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fire_c) begin
            state_q <= ST_PULSE;
            wcnt_q  <= PULSE_LAST;
            pulse_q <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (fire_c) begin
            wcnt_q <= PULSE_LAST;
          end else if (wcnt_q == '0) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pos        = pos_q;
  assign bus.dir        = dir_q;
  assign bus.quad_err   = qerr_q;
  assign bus.trig_pulse = pulse_q;
  assign bus.trig_cnt   = tcnt_q;

endmodule

// File: tb/tb_coder_pos_trigger.sv
// Bench for coder_pos_trigger: scoreboarded per-count checks, scenario table, corner sequences.
module tb_coder_pos_trigger;

  localparam int unsigned CNT_W     = 32;
  localparam int unsigned STEP_W    = 16;
  localparam int unsigned FILT_LEN  = 4;
  localparam int unsigned PULSE_LEN = 8;
  localparam int unsigned TCNT_W    = 16;
  localparam int          LAT       = 3 + FILT_LEN;

  logic              clk_sys  = 1'b0;
  logic              RESET_N  = 1'b0;
  logic              coder_a  = 1'b0;
  logic              coder_b  = 1'b0;
  logic              en       = 1'b0;
  logic              clr      = 1'b0;
  logic [1:0]        dir_mode = 2'b00;
  logic [STEP_W-1:0] step     = '0;

  coder_pos_trigger_if #(.CNT_W(CNT_W), .STEP_W(STEP_W), .TCNT_W(TCNT_W)) ifm ();
  coder_pos_trigger_if #(.CNT_W(8),     .STEP_W(STEP_W), .TCNT_W(TCNT_W)) ifw ();

  assign ifm.coder_a = coder_a;   assign ifw.coder_a = coder_a;
  assign ifm.coder_b = coder_b;   assign ifw.coder_b = coder_b;
  assign ifm.en = en;             assign ifw.en = en;
  assign ifm.clr = clr;           assign ifw.clr = clr;
  assign ifm.dir_mode = dir_mode; assign ifw.dir_mode = dir_mode;
  assign ifm.step = step;         assign ifw.step = step;

  coder_pos_trigger #(.CNT_W(CNT_W), .STEP_W(STEP_W), .FILT_LEN(FILT_LEN),
                      .PULSE_LEN(PULSE_LEN), .TCNT_W(TCNT_W))
    dut (.clk_sys(clk_sys), .RESET_N(RESET_N), .bus(ifm));

  coder_pos_trigger #(.CNT_W(8), .STEP_W(STEP_W), .FILT_LEN(FILT_LEN),
                      .PULSE_LEN(PULSE_LEN), .TCNT_W(TCNT_W))
    dut_w (.clk_sys(clk_sys), .RESET_N(RESET_N), .bus(ifw));

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard entry: expected outputs after one count and the cycle it must land
  typedef struct {
    logic [CNT_W-1:0]  pos;
    logic              dir;
    logic [TCNT_W-1:0] tcnt;
    logic              fire;
    int                due;
  } exp_t;
  exp_t sbq[$];

  logic [CNT_W-1:0] seen_pos;
  bit               mon_on = 1'b0;

  // Pop an expectation whenever pos moves; flag moves with nothing expected or late ones
  always @(negedge clk_sys) begin : mon
    exp_t e;
    if (!mon_on) begin
      seen_pos = ifm.pos;
    end else if (ifm.pos !== seen_pos) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pos_change", 64'(ifm.pos), 64'(seen_pos));
      end else begin
        e = sbq.pop_front();
        chk("pos", 64'(ifm.pos), 64'(e.pos));
        chk("pos_latency_cycle", 64'(cyc), 64'(e.due));
        chk("dir", 64'(ifm.dir), 64'(e.dir));
        chk("trig_cnt", 64'(ifm.trig_cnt), 64'(e.tcnt));
        if (e.fire) chk("trig_pulse_on_fire", 64'(ifm.trig_pulse), 64'd1);
      end
      seen_pos = ifm.pos;
    end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
      e = sbq.pop_front();
      chk("pos_late", 64'(ifm.pos), 64'(e.pos));
    end
  end

  // Pulse statistics: rising edges and width of the most recent completed pulse
  int   n_rise = 0;
  int   last_w = 0;
  int   cur_w  = 0;
  logic pl     = 1'b0;
  always @(negedge clk_sys) begin
    if (ifm.trig_pulse) begin
      if (!pl) begin
        n_rise++;
        cur_w = 0;
      end
      cur_w++;
    end else if (pl) begin
      last_w = cur_w;
    end
    pl = ifm.trig_pulse;
  end

  // Bench-side model of the coder state and trigger distance
  logic [1:0]        seq [4];
  int                q_idx  = 0;
  logic [CNT_W-1:0]  m_pos  = '0;
  logic [TCNT_W-1:0] m_tcnt = '0;
  int                m_dist = 0;

  task automatic drive_idx(input int idx);
    logic [1:0] v;
    q_idx   = idx;
    v       = seq[idx];
    coder_a = v[1];
    coder_b = v[0];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic step_q(input bit fwd, input int hold);
    exp_t e;
    bit   ok;
    e.fire = 1'b0;
    m_pos  = fwd ? m_pos + CNT_W'(1) : m_pos - CNT_W'(1);
    if (!en || dir_mode == 2'b11) begin
      m_dist = 0;
    end else begin
      ok = (dir_mode == 2'b00) || (dir_mode == 2'b01 && fwd) || (dir_mode == 2'b10 && !fwd);
      if (ok) begin
        m_dist++;
        if (step != 0 && m_dist >= int'(step)) begin
          m_dist = 0;
          m_tcnt = m_tcnt + TCNT_W'(1);
          e.fire = 1'b1;
        end
      end else if (m_dist > 0) begin
        m_dist--;
      end
    end
    e.pos  = m_pos;
    e.dir  = fwd;
    e.tcnt = m_tcnt;
    e.due  = cyc + LAT;
    sbq.push_back(e);
    drive_idx(fwd ? (q_idx + 1) % 4 : (q_idx + 3) % 4);
    tick(hold);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) tick(1);
    if (sbq.size() != 0) begin
      chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    tick(12);
  endtask

  task automatic do_clr();
    mon_on = 1'b0;
    clr    = 1'b1;
    tick(1);
    clr    = 1'b0;
    tick(3);
    m_pos  = '0;
    m_tcnt = '0;
    m_dist = 0;
    mon_on = 1'b1;
  endtask

  typedef struct {
    bit               en;
    logic [1:0]       dm;
    int               stp;
    int               f1;
    int               r;
    int               f2;
    logic [CNT_W-1:0] exp_pos;
    int               exp_tcnt;
    bit               exp_dir;
    int               exp_rise;
    int               exp_w;
  } vec_t;
  vec_t vt [7];

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    //        en   dm     step f1  r   f2  pos  tcnt dir rise width
    vt[0] = '{1'b0, 2'b00, 10, 40, 0,  0,  40,  0,   1'b1, 0, 0};
    vt[1] = '{1'b1, 2'b00, 10, 35, 0,  0,  35,  3,   1'b1, 3, 8};
    vt[2] = '{1'b1, 2'b01, 10, 7,  4,  7,  10,  1,   1'b1, 1, 8};
    vt[3] = '{1'b1, 2'b10, 5,  3,  12, 0,  -9,  2,   1'b0, 2, 8};
    vt[4] = '{1'b1, 2'b11, 2,  10, 0,  0,  10,  0,   1'b1, 0, 0};
    vt[5] = '{1'b1, 2'b00, 0,  10, 0,  0,  10,  0,   1'b1, 0, 0};
    vt[6] = '{1'b1, 2'b00, 4,  6,  6,  0,  0,   3,   1'b0, 3, 8};

    // Reset state
    tick(3);
    chk("reset_pos", 64'(ifm.pos), 64'd0);
    chk("reset_dir", 64'(ifm.dir), 64'd0);
    chk("reset_quad_err", 64'(ifm.quad_err), 64'd0);
    chk("reset_trig_pulse", 64'(ifm.trig_pulse), 64'd0);
    chk("reset_trig_cnt", 64'(ifm.trig_cnt), 64'd0);
    @(negedge clk_sys);
    RESET_N = 1'b1;
    tick(4);
    mon_on = 1'b1;

    // Scenario table
    for (int i = 0; i < 7; i++) begin
      en       = vt[i].en;
      dir_mode = vt[i].dm;
      step     = STEP_W'(vt[i].stp);
      do_clr();
      n_rise = 0;
      last_w = 0;
      for (int k = 0; k < vt[i].f1; k++) step_q(1'b1, 10);
      for (int k = 0; k < vt[i].r;  k++) step_q(1'b0, 10);
      for (int k = 0; k < vt[i].f2; k++) step_q(1'b1, 10);
      drain();
      chk($sformatf("vec%0d_pos", i), 64'(ifm.pos), 64'(vt[i].exp_pos));
      chk($sformatf("vec%0d_trig_cnt", i), 64'(ifm.trig_cnt), 64'(vt[i].exp_tcnt));
      chk($sformatf("vec%0d_dir", i), 64'(ifm.dir), 64'(vt[i].exp_dir));
      chk($sformatf("vec%0d_quad_err", i), 64'(ifm.quad_err), 64'd0);
      chk($sformatf("vec%0d_pulses", i), 64'(n_rise), 64'(vt[i].exp_rise));
      if (vt[i].exp_w != 0)
        chk($sformatf("vec%0d_pulse_width", i), 64'(last_w), 64'(vt[i].exp_w));
    end

    // Short glitch is filtered out, then a double-bit jump sets sticky quad_err
    en = 1'b0;
    do_clr();
    step_q(1'b1, 10);
    drain();
    coder_a = ~coder_a;
    tick(3);
    coder_a = ~coder_a;
    tick(15);
    chk("glitch_pos", 64'(ifm.pos), 64'(m_pos));
    chk("glitch_quad_err", 64'(ifm.quad_err), 64'd0);
    drive_idx((q_idx + 2) % 4);
    tick(15);
    chk("jump_quad_err", 64'(ifm.quad_err), 64'd1);
    chk("jump_pos", 64'(ifm.pos), 64'(m_pos));
    step_q(1'b1, 10);
    drain();
    chk("quad_err_sticky", 64'(ifm.quad_err), 64'd1);
    do_clr();
    chk("quad_err_clr", 64'(ifm.quad_err), 64'd0);

    // Wrap on an 8-bit sibling, then clr colliding with a count that would fire
    en       = 1'b1;
    dir_mode = 2'b00;
    step     = STEP_W'(3);
    do_clr();
    for (int k = 0; k < 127; k++) step_q(1'b1, 6);
    drain();
    chk("wrap8_pre_max", 64'(ifm.pos), 64'd127);
    chk("wrap8_pos_7f", 64'(ifw.pos), 64'h7F);
    step_q(1'b1, 6);
    drain();
    chk("wrap8_pos_80", 64'(ifw.pos), 64'h80);
    chk("wrap8_main_pos", 64'(ifm.pos), 64'd128);
    chk("wrap8_trig_cnt", 64'(ifm.trig_cnt), 64'd42);
    mon_on = 1'b0;
    n_rise = 0;
    drive_idx((q_idx + 1) % 4);
    tick(LAT - 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(12);
    chk("clr_with_count_pos", 64'(ifm.pos), 64'd0);
    chk("clr_with_count_trig_cnt", 64'(ifm.trig_cnt), 64'd0);
    chk("clr_with_count_no_fire", 64'(n_rise), 64'd0);
    chk("clr_with_count_pos8", 64'(ifw.pos), 64'd0);
    m_pos  = '0;
    m_tcnt = '0;
    m_dist = 0;
    mon_on = 1'b1;

    // step=1 with counts 4 cycles apart: one continuous extended pulse
    step = STEP_W'(1);
    do_clr();
    n_rise = 0;
    last_w = 0;
    for (int k = 0; k < 6; k++) step_q(1'b1, 4);
    drain();
    chk("extend_rises", 64'(n_rise), 64'd1);
    chk("extend_width", 64'(last_w), 64'(5 * 4 + PULSE_LEN));
    chk("extend_trig_cnt", 64'(ifm.trig_cnt), 64'd6);

    // Asynchronous reset in the middle of a pulse
    step_q(1'b1, 10);
    chk("pre_reset_pulse_high", 64'(ifm.trig_pulse), 64'd1);
    mon_on  = 1'b0;
    RESET_N = 1'b0;
    #1;
    chk("async_reset_pulse", 64'(ifm.trig_pulse), 64'd0);
    chk("async_reset_pos", 64'(ifm.pos), 64'd0);
    chk("async_reset_trig_cnt", 64'(ifm.trig_cnt), 64'd0);
    sbq.delete();
    tick(2);
    RESET_N = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
